scale_mode_sync: RTL and testbench

Downstream of the touch-key mode switch: consumes the one-hot `change_en` scale-mode select and turns it into a frame-aligned scaler configuration (output width/height and 12.16 fixed-point step ratios). Steps are computed by a serial divider whenever the requested mode changes. The result is committed only on a vsync rising edge, so the scaler never changes geometry mid-frame.

---
 rtl/scale_pkg.sv | 42 ++++
 rtl/scale_step_div.sv | 61 ++++++
 rtl/scale_mode_sync.sv | 123 ++++++++++++
 tb/tb_scale_mode_sync.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/scale_pkg.sv
// rtl/scale_pkg.sv - shared constants, mode lookup and FSM state type for the scale mode sync block
package scale_pkg;

    localparam int FRAC  = 16;
    localparam int DVD_W = 28;
    localparam int DVS_W = 12;

    localparam logic [2:0] MODE_640 = 3'b001;
    localparam logic [2:0] MODE_800 = 3'b010;
    localparam logic [2:0] MODE_320 = 3'b100;

    localparam logic [DVS_W-1:0] W_640 = 12'd640;
    localparam logic [DVS_W-1:0] H_640 = 12'd480;
    localparam logic [DVS_W-1:0] W_800 = 12'd800;
    localparam logic [DVS_W-1:0] H_800 = 12'd600;
    localparam logic [DVS_W-1:0] W_320 = 12'd320;
    localparam logic [DVS_W-1:0] H_320 = 12'd240;

    typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, WAIT_VS} state_t;

    function automatic logic is_mode(input logic [2:0] code);
        return (code == MODE_640) || (code == MODE_800) || (code == MODE_320);
    endfunction

    // Non-mode codes never reach these lookups; the default keeps divisors nonzero.
    function automatic logic [DVS_W-1:0] mode_w(input logic [2:0] code);
        case (code)
            MODE_800: return W_800;
            MODE_320: return W_320;
            default:  return W_640;
        endcase
    endfunction

    function automatic logic [DVS_W-1:0] mode_h(input logic [2:0] code);
        case (code)
            MODE_800: return H_800;
            MODE_320: return H_320;
            default:  return H_640;
        endcase
    endfunction

endpackage

// File: rtl/scale_step_div.sv
// rtl/scale_step_div.sv - 28-by-12 bit serial restoring divider, one quotient bit per cycle
module scale_step_div
    import scale_pkg::*;
(
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic             abort,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic [DVD_W-1:0] quotient,
    output logic             done
);

    // shreg starts as the dividend and fills with quotient bits from the right.
    logic [DVD_W-1:0] shreg;
    logic [DVS_W-1:0] rem;
    logic [DVS_W-1:0] dvs;
    logic [4:0]       cnt;
    logic             running;
    logic [DVS_W:0]   trial;
    logic [DVS_W:0]   diff;
    logic             q_bit;
    logic [DVS_W-1:0] rem_next;

    always_comb begin
        trial    = {rem, shreg[DVD_W-1]};
        diff     = trial - {1'b0, dvs};
        q_bit    = (trial >= {1'b0, dvs});
        rem_next = q_bit ? diff[DVS_W-1:0] : trial[DVS_W-1:0];
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            shreg   <= '0;
            rem     <= '0;
            dvs     <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            shreg   <= dividend;
            dvs     <= divisor;
            rem     <= '0;
            cnt     <= 5'(DVD_W - 1);
            running <= 1'b1;
        end else if (abort) begin
            running <= 1'b0;
        end else if (running) begin
            shreg <= {shreg[DVD_W-2:0], q_bit};
            rem   <= rem_next;
            cnt   <= cnt - 5'd1;
            if (cnt == 5'd0) begin
                running <= 1'b0;
            end
        end
    end

    assign done     = running && (cnt == 5'd0);
    assign quotient = {shreg[DVD_W-2:0], q_bit};

endmodule

// File: rtl/scale_mode_sync.sv
// rtl/scale_mode_sync.sv - turns one-hot mode requests into vsync-aligned scaler geometry and step ratios
module scale_mode_sync #(
    parameter int IN_W = 640,
    parameter int IN_H = 480,
    parameter int FRAC = scale_pkg::FRAC
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [2:0]  change_en,
    input  logic        vs_in,
    output logic [11:0] out_w,
    output logic [11:0] out_h,
    output logic [27:0] step_x,
    output logic [27:0] step_y,
    output logic        cfg_valid,
    output logic        busy
);
    import scale_pkg::*;

    localparam logic [DVD_W-1:0] DIVIDEND_X = DVD_W'(IN_W) << FRAC;
    localparam logic [DVD_W-1:0] DIVIDEND_Y = DVD_W'(IN_H) << FRAC;
    localparam logic [DVD_W-1:0] STEP_ONE   = DVD_W'(1) << FRAC;

    state_t           state, next_state;
    logic [2:0]       cur_code;
    logic [DVS_W-1:0] tgt_w, tgt_h;
    logic [DVD_W-1:0] shadow_x, shadow_y;
    logic             vs_meta, vs_sync, vs_prev, vs_rise;
    logic             detect, commit;
    logic             div_start, div_abort, div_done;
    logic [DVD_W-1:0] div_dividend, div_quotient;
    logic [DVS_W-1:0] div_divisor;

    assign detect  = is_mode(change_en) && (change_en != cur_code);
    assign vs_rise = vs_sync && !vs_prev;
    assign busy    = (state != IDLE);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A fresh request always wins, even over a vsync edge in WAIT_VS.
    always_comb begin
        next_state   = state;
        div_start    = 1'b0;
        div_abort    = 1'b0;
        div_dividend = DIVIDEND_X;
        div_divisor  = mode_w(change_en);
        commit       = 1'b0;
        if (detect) begin
            next_state = DIV_X;
            div_start  = 1'b1;
            div_abort  = (state != IDLE);
        end else begin
            case (state)
                DIV_X: if (div_done) begin
                    next_state   = DIV_Y;
                    div_start    = 1'b1;
                    div_dividend = DIVIDEND_Y;
                    div_divisor  = tgt_h;
                end
                DIV_Y: if (div_done) next_state = WAIT_VS;
                WAIT_VS: if (vs_rise) begin
                    commit     = 1'b1;
                    next_state = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cur_code  <= 3'b000;
            tgt_w     <= W_640;
            tgt_h     <= H_640;
            shadow_x  <= STEP_ONE;
            shadow_y  <= STEP_ONE;
            out_w     <= 12'(IN_W);
            out_h     <= 12'(IN_H);
            step_x    <= STEP_ONE;
            step_y    <= STEP_ONE;
            cfg_valid <= 1'b0;
            vs_meta   <= 1'b0;
            vs_sync   <= 1'b0;
            vs_prev   <= 1'b0;
        end else begin
            vs_meta   <= vs_in;
            vs_sync   <= vs_meta;
            vs_prev   <= vs_sync;
            cfg_valid <= commit;
            if (detect) begin
                cur_code <= change_en;
                tgt_w    <= mode_w(change_en);
                tgt_h    <= mode_h(change_en);
            end
            if (!detect && div_done && state == DIV_X) shadow_x <= div_quotient;
            if (!detect && div_done && state == DIV_Y) shadow_y <= div_quotient;
            if (commit) begin
                out_w  <= tgt_w;
                out_h  <= tgt_h;
                step_x <= shadow_x;
                step_y <= shadow_y;
            end
        end
    end

    scale_step_div u_div (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .start    (div_start),
        .abort    (div_abort),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .quotient (div_quotient),
        .done     (div_done)
    );

endmodule

// File: tb/tb_scale_mode_sync.sv
// tb/tb_scale_mode_sync.sv - randomized scoreboard bench for scale_mode_sync
module tb_scale_mode_sync;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [2:0]  change_en;
    logic        vs_in;
    logic [11:0] out_w, out_h;
    logic [27:0] step_x, step_y;
    logic        cfg_valid, busy;

    always #10 sys_clk = ~sys_clk;

    scale_mode_sync dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .change_en (change_en),
        .vs_in     (vs_in),
        .out_w     (out_w),
        .out_h     (out_h),
        .step_x    (step_x),
        .step_y    (step_y),
        .cfg_valid (cfg_valid),
        .busy      (busy)
    );

    typedef struct {
        int w;
        int h;
        int sx;
        int sy;
    } cfg_t;

    cfg_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [2:0] m_cur;
    bit         m_pend;
    int         m_det;

    function automatic cfg_t model_cfg(input logic [2:0] code);
        cfg_t c;
        case (code)
            3'b010:  begin c.w = 800; c.h = 600; end
            3'b100:  begin c.w = 320; c.h = 240; end
            default: begin c.w = 640; c.h = 480; end
        endcase
        c.sx = (640 * 65536) / c.w;
        c.sy = (480 * 65536) / c.h;
        return c;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic request(input logic [2:0] code);
        change_en = code;
        if ($onehot(code) && code != m_cur) begin
            m_cur  = code;
            m_pend = 1'b1;
            m_det  = cyc;
        end
    endtask

    // Pulses are only issued well inside a computation (no commit) or well after it.
    task automatic vs_pulse();
        if (m_pend && (cyc - m_det) >= 60) begin
            exp_q.push_back(model_cfg(m_cur));
            m_pend = 1'b0;
        end
        vs_in = 1'b1;
        ticks(3);
        vs_in = 1'b0;
        ticks(6);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_w"}, int'(out_w), 640);
        chk({tag, "_out_h"}, int'(out_h), 480);
        chk({tag, "_step_x"}, int'(step_x), 65536);
        chk({tag, "_step_y"}, int'(step_y), 65536);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_cfg_valid"}, int'(cfg_valid), 0);
    endtask

    always @(negedge sys_clk) begin
        if (cfg_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_commit: got cfg_valid=1 w=%0d h=%0d expected no commit", out_w, out_h);
            end else begin
                cfg_t e;
                e = exp_q.pop_front();
                chk("commit_out_w", int'(out_w), e.w);
                chk("commit_out_h", int'(out_h), e.h);
                chk("commit_step_x", int'(step_x), e.sx);
                chk("commit_step_y", int'(step_y), e.sy);
                chk("commit_busy", int'(busy), 0);
            end
        end
    end

    initial begin
        logic [2:0] code;
        sys_rst   = 1'b1;
        change_en = 3'b100;
        vs_in     = 1'b0;
        m_cur     = 3'b000;
        m_pend    = 1'b0;
        m_det     = 0;
        ticks(3);
        chk_reset_outputs("reset");

        sys_rst = 1'b0;
        request(3'b100);
        chk("busy_before_detect", int'(busy), 0);
        tick();
        chk("busy_t_plus_1", int'(busy), 1);
        ticks(45);
        chk("busy_mid_compute", int'(busy), 1);
        chk("hold_out_w", int'(out_w), 640);
        chk("hold_step_x", int'(step_x), 65536);
        ticks(20);
        chk("busy_waiting_vs", int'(busy), 1);
        vs_pulse();
        chk("busy_after_commit", int'(busy), 0);

        request(3'b001);
        ticks(62);
        vs_pulse();
        request(3'b010);
        ticks(62);
        vs_pulse();

        // vsync during DIV_Y is ignored; the next one commits
        request(3'b100);
        ticks(35);
        vs_pulse();
        chk("busy_after_early_vs", int'(busy), 1);
        ticks(25);
        vs_pulse();

        // request change during DIV_X restarts the computation
        request(3'b001);
        ticks(10);
        request(3'b010);
        ticks(62);
        vs_pulse();

        request(3'b011);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("busy_invalid_code", int'(busy), 0);
        end

        for (int n = 0; n < 10; n++) begin
            code = 3'($urandom_range(0, 7));
            request(code);
            tick();
            chk("busy_after_random_req", int'(busy), int'(m_pend));
            ticks($urandom_range(60, 90));
            vs_pulse();
        end

        // reset while waiting for vsync discards the pending request
        request((m_cur == 3'b001) ? 3'b100 : 3'b001);
        ticks(62);
        chk("busy_before_reset", int'(busy), 1);
        sys_rst = 1'b1;
        tick();
        chk_reset_outputs("mid_reset");
        change_en = 3'b000;
        m_cur     = 3'b000;
        m_pend    = 1'b0;
        tick();
        sys_rst = 1'b0;
        vs_pulse();
        chk("busy_after_reset_vs", int'(busy), 0);
        chk("out_w_after_reset_vs", int'(out_w), 640);

        ticks(5);
        chk("pending_commits", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
